instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end for the MIPS datapath: owns the fetch program counter, drives the word address into the asynchronous-read instruction memory, captures the returned word, and buffers fetched instructions (with their PCs) in a small FIFO. Decode drains the FIFO through a valid/ready handshake. Branch/jump resolution redirects fetch through a single-cycle `Redirect` pulse that flushes the buffer.

## Interface
- `RESET_PC`, 32'h00000000: fetch PC loaded at reset; bits [1:0] must be 0.
- `DEPTH`, 4: FIFO entries; power of two, 2..16.

- `Clk`  in  1: single clock, rising edge.
- `Rst_n`  in  1: asynchronous, active-low reset.
- `FetchEn`  in  1: permits fetching; does not block draining.
- `IAddr`  out  32: byte address to instruction memory, equals fetch PC.
- `IData`  in  32: instruction word returned combinationally for `IAddr`.
- `Redirect`  in  1: one-cycle pulse; flush and restart fetch.
- `RedirectPC`  in  32: new fetch PC; bits [1:0] are ignored (forced 0).
- `InstrValid`  out  1: FIFO head holds a valid instruction.
- `InstrReady`  in  1: decode accepts the head this cycle.
- `Instr`  out  32: FIFO head instruction; 0 when empty.
- `InstrPC`  out  32: byte PC of `Instr`; 0 when empty.
- `FetchCount`  out  32: words pushed since reset; wraps modulo 2^32.

## Operation
- States: IDLE, RUN. Reset -> IDLE.
  - IDLE -> RUN on a clock edge with `FetchEn`=1. No fetch occurs in IDLE.
  - RUN -> IDLE on an edge with `FetchEn`=0. FIFO contents remain and keep draining.
  - `Redirect` does not change state.
- pop = `InstrValid` & `InstrReady`.
- fetch = RUN & `FetchEn` & !`Redirect` & (count < `DEPTH` | pop).
- On fetch: push {`IData`, PC}; PC <= PC+4; `FetchCount`++.
  - PC 32'hFFFFFFFC wraps to 0.
- Push and pop in the same cycle: count unchanged, ordering preserved.
- Full FIFO with pop: the fetch still occurs (fall-through of the freed slot).
- `Redirect`: takes priority over push and pop.
  - FIFO emptied (count <= 0).
  - PC <= {`RedirectPC`[31:2], 2'b00}.
  - A concurrent pop is discarded; decode must treat it as squashed.
  - `FetchCount` does not increment.
- Read and write pointers are log2(`DEPTH`) bits and wrap naturally. Count is log2(`DEPTH`)+1 bits.
- `IAddr` is driven directly from the PC register, never from combinational inputs.

## Timing
- Reset values:
  - PC = `RESET_PC`, so `IAddr` = `RESET_PC`.
  - state = IDLE.
  - count = 0.
  - `InstrValid` = 0, `Instr` = 0, `InstrPC` = 0, `FetchCount` = 0.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge.
- Startup sequence:
  - Edge 1 with `FetchEn`=1: IDLE -> RUN, no fetch.
  - Edge 2: first fetch. `InstrValid` rises after edge 2.
- Fetch-to-visible latency: 1 edge. `IData` is sampled at the edge; the entry is on `Instr` after that edge if the FIFO was empty.
- Steady state with `InstrReady`=1: one instruction per cycle.
- With `InstrReady`=0: the FIFO fills after `DEPTH` fetches, then `IAddr` holds.
- Redirect:
  - `InstrValid`=0 in the cycle after the `Redirect` edge.
  - `IAddr`=`RedirectPC` in the cycle after the `Redirect` edge.
  - The first redirected instruction is visible 2 cycles after `Redirect` (if RUN and `FetchEn`).
- `Redirect` in IDLE: PC updated and FIFO flushed; fetching waits until RUN.

## Test plan
- Reset behaviour.
  - Stimulus: memory model with word0=32'h8c19003b, word1=32'h8c18003a. `FetchEn`=1, `InstrReady`=1 after reset release.
  - Response: `IAddr` 0,0,4,8…; `Instr`/`InstrPC` show 8c19003b/0, then 8c18003a/4; `FetchCount`=2 after two fetches.
- Backpressure.
  - Stimulus: `InstrReady`=0 for 8 cycles in RUN, `DEPTH`=4.
  - Response: exactly 4 pushes; `IAddr` frozen at 0x10; `FetchCount`=4. Release `InstrReady` -> PCs 0,4,8,C,10 in order, no gaps or duplicates.
- Full-with-pop.
  - Stimulus: FIFO full, `InstrReady`=1 for one cycle.
  - Response: one pop and one push on the same edge; count stays 4; `IAddr` advances by 4.
- Redirect.
  - Stimulus: `Redirect` with `RedirectPC`=32'h00000093 while FIFO holds 3 entries and `InstrReady`=1.
  - Response: next cycle `InstrValid`=0, `IAddr`=0x90; the cycle after, `InstrPC`=0x90; `FetchCount` not incremented on the redirect edge.
- PC wrap.
  - Stimulus: `RESET_PC`=32'hFFFFFFF8.
  - Response: `IAddr` sequence FFFFFFF8, FFFFFFFC, 00000000.
- Asynchronous reset.
  - Stimulus: `Rst_n` pulled low between edges with 2 entries buffered.
  - Response: `InstrValid`, `Instr`, and `FetchCount` go to 0 and `IAddr` to `RESET_PC` before the next edge; state returns to IDLE.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory port, redirect input and the
// decode valid/ready handshake. The fetch unit is the master.
interface instr_fetch_unit_if;
    logic        FetchEn;
    logic [31:0] IAddr;
    logic [31:0] IData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic [31:0] FetchCount;

    modport master (
        input  FetchEn, IData, Redirect, RedirectPC, InstrReady,
        output IAddr, InstrValid, Instr, InstrPC, FetchCount
    );

    modport slave (
        output FetchEn, IData, Redirect, RedirectPC, InstrReady,
        input  IAddr, InstrValid, Instr, InstrPC, FetchCount
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS fetch front end: PC register driving an async-read instruction memory,
// followed by a small instruction/PC FIFO drained by decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    instr_fetch_unit_if.master  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fetch_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0] instr_q [DEPTH];
    logic [31:0] pc_q    [DEPTH];

    logic valid;
    logic full;
    logic pop;
    logic fetch;

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = valid & bus.InstrReady;
    // A full buffer can still accept a push when the head leaves on the same edge.
    assign fetch = (state == RUN) & bus.FetchEn & ~bus.Redirect & (~full | pop);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fetch_count <= '0;
        end else begin
            state <= bus.FetchEn ? RUN : IDLE;
            if (bus.Redirect) begin
                // Flush by collapsing the read pointer onto the write pointer.
                pc     <= {bus.RedirectPC[31:2], 2'b00};
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (fetch) begin
                    pc          <= pc + 32'd4;
                    wr_ptr      <= wr_ptr + 1'b1;
                    fetch_count <= fetch_count + 32'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (fetch && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !fetch) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge Clk) begin
        if (fetch) begin
            instr_q[wr_ptr] <= bus.IData;
            pc_q[wr_ptr]    <= pc;
        end
    end

    assign bus.IAddr      = pc;
    assign bus.InstrValid = valid;
    assign bus.Instr      = valid ? instr_q[rd_ptr] : 32'd0;
    assign bus.InstrPC    = valid ? pc_q[rd_ptr]    : 32'd0;
    assign bus.FetchCount = fetch_count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run, all
// compared against a queue-based reference model of the fetch buffer.
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC  = 32'h00000000;
    localparam logic [31:0] WRAP_PC = 32'hFFFFFFF8;

    logic Clk;
    logic Rst_n;
    int   total;
    int   passed;

    instr_fetch_unit_if if0 ();
    instr_fetch_unit_if if1 ();

    instr_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (if0)
    );

    instr_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (if1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8c19003b;
        if (a == 32'h4) return 32'h8c18003a;
        return (a * 32'h9E3779B1) ^ 32'hDEADBEEF;
    endfunction

    assign if0.IData = mem_word(if0.IAddr);
    assign if1.IData = mem_word(if1.IAddr);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: a queue of {instr, pc} entries plus fetch PC and counter.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_run;

    task automatic model_reset();
        m_q.delete();
        m_pc  = RST_PC;
        m_cnt = 32'd0;
        m_run = 1'b0;
    endtask

    task automatic model_edge();
        bit do_pop;
        bit do_fetch;
        do_pop = (m_q.size() != 0) && if0.InstrReady;
        if (if0.Redirect) begin
            m_q.delete();
            m_pc = {if0.RedirectPC[31:2], 2'b00};
        end else begin
            do_fetch = m_run && if0.FetchEn && ((m_q.size() < DEPTH) || do_pop);
            if (do_pop) void'(m_q.pop_front());
            if (do_fetch) begin
                m_q.push_back({mem_word(m_pc), m_pc});
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
        m_run = if0.FetchEn;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        e_instr = 32'd0;
        e_pc    = 32'd0;
        if (m_q.size() != 0) begin
            e_instr = m_q[0][63:32];
            e_pc    = m_q[0][31:0];
        end
        chk({tag, ".IAddr"},      if0.IAddr,              m_pc);
        chk({tag, ".InstrValid"}, {31'd0, if0.InstrValid}, {31'd0, m_q.size() != 0});
        chk({tag, ".Instr"},      if0.Instr,              e_instr);
        chk({tag, ".InstrPC"},    if0.InstrPC,            e_pc);
        chk({tag, ".FetchCount"}, if0.FetchCount,         m_cnt);
    endtask

    // Advance one clock: model takes the edge with the inputs the DUT sees,
    // outputs are compared 1 time unit after the edge.
    task automatic tick(input string tag);
        model_edge();
        @(posedge Clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        if0.FetchEn = 1'b0; if0.InstrReady = 1'b0;
        if0.Redirect = 1'b0; if0.RedirectPC = 32'd0;
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        bit last_redir;
        total  = 0;
        passed = 0;
        if1.FetchEn = 1'b0; if1.InstrReady = 1'b1;
        if1.Redirect = 1'b0; if1.RedirectPC = 32'd0;

        // Reset state
        Rst_n = 1'b0;
        if0.FetchEn = 1'b0; if0.InstrReady = 1'b0;
        if0.Redirect = 1'b0; if0.RedirectPC = 32'd0;
        model_reset();
        #2;
        check_model("reset");
        @(negedge Clk);
        Rst_n = 1'b1;

        // Startup and first fetches, plus PC wrap on the second instance
        if0.FetchEn = 1'b1; if0.InstrReady = 1'b1;
        if1.FetchEn = 1'b1;
        tick("start1");
        chk("start1.IAddr_const", if0.IAddr, 32'h0);
        chk("wrap1.IAddr", if1.IAddr, 32'hFFFFFFF8);
        tick("start2");
        chk("start2.Instr_const", if0.Instr, 32'h8c19003b);
        chk("start2.InstrPC_const", if0.InstrPC, 32'h0);
        chk("wrap2.IAddr", if1.IAddr, 32'hFFFFFFFC);
        chk("wrap2.InstrPC", if1.InstrPC, 32'hFFFFFFF8);
        tick("start3");
        chk("start3.Instr_const", if0.Instr, 32'h8c18003a);
        chk("start3.InstrPC_const", if0.InstrPC, 32'h4);
        chk("start3.FetchCount_const", if0.FetchCount, 32'd2);
        chk("wrap3.IAddr", if1.IAddr, 32'h00000000);
        for (int i = 0; i < 3; i++) tick("steady");

        // Backpressure: 8 RUN cycles with decode stalled
        do_reset();
        if0.FetchEn = 1'b1; if0.InstrReady = 1'b0;
        tick("bp_idle");
        for (int i = 0; i < 8; i++) tick("bp");
        chk("bp.IAddr_const", if0.IAddr, 32'h10);
        chk("bp.FetchCount_const", if0.FetchCount, 32'd4);
        chk("bp.head_const", if0.InstrPC, 32'h0);

        // Full with pop, then drain in order
        if0.InstrReady = 1'b1;
        tick("fullpop");
        chk("fullpop.IAddr_const", if0.IAddr, 32'h14);
        chk("fullpop.FetchCount_const", if0.FetchCount, 32'd5);
        chk("fullpop.InstrPC_const", if0.InstrPC, 32'h4);
        for (int i = 0; i < 4; i++) begin
            tick("drain");
            chk("drain.InstrPC_const", if0.InstrPC, 32'h8 + 32'(i) * 32'd4);
        end

        // Redirect with three buffered entries
        do_reset();
        if0.FetchEn = 1'b1; if0.InstrReady = 1'b0;
        for (int i = 0; i < 4; i++) tick("rd_fill");
        if0.InstrReady = 1'b1;
        if0.Redirect = 1'b1; if0.RedirectPC = 32'h00000093;
        tick("redir");
        chk("redir.InstrValid_const", {31'd0, if0.InstrValid}, 32'd0);
        chk("redir.IAddr_const", if0.IAddr, 32'h90);
        chk("redir.FetchCount_const", if0.FetchCount, 32'd3);
        if0.Redirect = 1'b0;
        tick("redir2");
        chk("redir2.InstrPC_const", if0.InstrPC, 32'h90);

        // Asynchronous reset between edges with two entries buffered
        do_reset();
        if0.FetchEn = 1'b1; if0.InstrReady = 1'b0;
        for (int i = 0; i < 3; i++) tick("ar_fill");
        #2;
        Rst_n = 1'b0;
        model_reset();
        #1;
        check_model("async_rst");
        @(negedge Clk);
        Rst_n = 1'b1;
        tick("ar_idle");
        tick("ar_run");

        // Randomized traffic including redirects
        last_redir = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if0.FetchEn    = ($urandom_range(0, 7) != 0);
            if0.InstrReady = $urandom_range(0, 1) == 1;
            if0.Redirect   = !last_redir && ($urandom_range(0, 15) == 0);
            if0.RedirectPC = $urandom;
            last_redir     = if0.Redirect;
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
